// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request controller.
//   OP_ADD/OP_SUB/OP_MUL/OP_DIV : FPU_Core opcode values
//   QNAN                        : result word returned for an illegal opcode
//   FLAGS_ILLEGAL               : rsp_flags value for an illegal opcode
//   state_t                     : controller FSM encoding (IDLE, WAIT, RESP)
//   op_legal()                  : true when the opcode is one FPU_Core implements
package fpu_pkg;

    localparam logic [3:0]  OP_ADD = 4'd0;
    localparam logic [3:0]  OP_SUB = 4'd1;
    localparam logic [3:0]  OP_MUL = 4'd2;
    localparam logic [3:0]  OP_DIV = 4'd3;

    localparam logic [31:0] QNAN          = 32'h7FC0_0000;
    localparam logic [3:0]  FLAGS_ILLEGAL = 4'b1000;

    // Wide enough for FPU_LAT up to 15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_DIV;
    endfunction

endpackage

// File: rtl/fpu_wait_cnt.sv
// Latency counter for the FPU request controller.
// Loads a start value, counts down once per dec cycle, and flags done when
// the count reads 1 (the last wait cycle).
//   clk, rst_n : clock, asynchronous active-low reset (count cleared)
//   load       : load load_val (has priority over dec)
//   load_val   : start value
//   dec        : decrement when non-zero
//   done       : count == 1
module fpu_wait_cnt
    import fpu_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/fpu_req_ctrl.sv
// FPU request controller: accepts one command at a time, drives FPU_Core
// operands, waits FPU_LAT clocks, and returns the result with flags over a
// valid/ready response handshake. Illegal opcodes (> 3) bypass FPU_Core and
// answer with a quiet NaN.
// Optional feature macro: FPU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags.
// Ports:
//   Clk, RstN                      : clock, asynchronous active-low reset
//   req_valid/req_ready            : command handshake (ready only in IDLE)
//   req_a, req_b, req_op           : command operands and opcode
//   a_operand, b_operand, Operation: registered drive to FPU_Core
//   FPU_Output, Exception, Overflow, Underflow : FPU_Core result
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data, rsp_flags            : result word, {illegal_op, Exception, Overflow, Underflow}
//   sticky_clr, sticky_flags       : (FPU_STICKY_FLAGS_EN) accumulated delivered flags
module fpu_req_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned FPU_LAT = 1
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_op,
    output logic [31:0] a_operand,
    output logic [31:0] b_operand,
    output logic [3:0]  Operation,
    input  logic [31:0] FPU_Output,
    input  logic        Exception,
    input  logic        Overflow,
    input  logic        Underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags
`ifdef FPU_STICKY_FLAGS_EN
    ,
    input  logic        sticky_clr,
    output logic [3:0]  sticky_flags
`endif
);

    state_t state;
    state_t next_state;

    logic accept_legal;
    logic accept_illegal;
    logic capture;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_done;

    fpu_wait_cnt #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk      (Clk),
        .rst_n    (RstN),
        .load     (cnt_load),
        .load_val (CNT_W'(FPU_LAT)),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        case (state)
            IDLE: begin
                // Gated by RstN so ready stays low while reset is held,
                // even though the state register already sits in IDLE.
                req_ready = RstN;
                if (req_valid) begin
                    if (op_legal(req_op)) begin
                        accept_legal = 1'b1;
                        cnt_load     = 1'b1;
                        next_state   = WAIT;
                    end else begin
                        accept_illegal = 1'b1;
                        next_state     = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand drive only changes on a legal accept; response registers only
    // change on capture or illegal accept, so both hold across a stalled RESP.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            a_operand <= '0;
            b_operand <= '0;
            Operation <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept_legal) begin
                a_operand <= req_a;
                b_operand <= req_b;
                Operation <= req_op;
            end
            if (capture) begin
                rsp_data  <= FPU_Output;
                rsp_flags <= {1'b0, Exception, Overflow, Underflow};
            end else if (accept_illegal) begin
                rsp_data  <= QNAN;
                rsp_flags <= FLAGS_ILLEGAL;
            end
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sticky_flags <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end else if (rsp_valid && rsp_ready) begin
            sticky_flags <= sticky_flags | rsp_flags;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// Self-checking bench for fpu_req_ctrl. Instance 0 uses FPU_LAT=1, instance 1
// uses FPU_LAT=4; each is attached to a combinational FPU_Core stub.
module tb_fpu_req_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic [3:0]  req_op    [2];
    logic [31:0] a_op      [2];
    logic [31:0] b_op      [2];
    logic [3:0]  op_out    [2];
    logic [31:0] fpu_out   [2];
    logic        exc       [2];
    logic        ovf       [2];
    logic        unf       [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic [3:0]  rsp_flags [2];
`ifdef FPU_STICKY_FLAGS_EN
    logic        sticky_clr   [2];
    logic [3:0]  sticky_flags [2];
`endif

    int checks = 0;
    int errors = 0;

    // FPU_Core stub: arbitrary but deterministic result and flags.
    function automatic logic [31:0] stub_result(input logic [31:0] a, input logic [31:0] b,
                                                input logic [3:0] op);
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
    endfunction

    function automatic logic [2:0] stub_flags(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        return {(op == 4'd3) && (b[30:0] == 31'd0), a[0], b[0]};
    endfunction

    // Reference model of a command's response.
    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        return (op > 4'd3) ? 32'h7FC0_0000 : stub_result(a, b, op);
    endfunction

    function automatic logic [3:0] exp_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        return (op > 4'd3) ? 4'b1000 : {1'b0, stub_flags(a, b, op)};
    endfunction

    function automatic int exp_lat(input int lat_param, input logic [3:0] op);
        return (op > 4'd3) ? 1 : lat_param + 1;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    assign fpu_out[0] = stub_result(a_op[0], b_op[0], op_out[0]);
    assign fpu_out[1] = stub_result(a_op[1], b_op[1], op_out[1]);
    assign {exc[0], ovf[0], unf[0]} = stub_flags(a_op[0], b_op[0], op_out[0]);
    assign {exc[1], ovf[1], unf[1]} = stub_flags(a_op[1], b_op[1], op_out[1]);

    fpu_req_ctrl #(.FPU_LAT(1)) dut1 (
        .Clk(clk), .RstN(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
        .a_operand(a_op[0]), .b_operand(b_op[0]), .Operation(op_out[0]),
        .FPU_Output(fpu_out[0]), .Exception(exc[0]), .Overflow(ovf[0]), .Underflow(unf[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_flags(rsp_flags[0])
`ifdef FPU_STICKY_FLAGS_EN
        , .sticky_clr(sticky_clr[0]), .sticky_flags(sticky_flags[0])
`endif
    );

    fpu_req_ctrl #(.FPU_LAT(4)) dut4 (
        .Clk(clk), .RstN(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
        .a_operand(a_op[1]), .b_operand(b_op[1]), .Operation(op_out[1]),
        .FPU_Output(fpu_out[1]), .Exception(exc[1]), .Overflow(ovf[1]), .Underflow(unf[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_flags(rsp_flags[1])
`ifdef FPU_STICKY_FLAGS_EN
        , .sticky_clr(sticky_clr[1]), .sticky_flags(sticky_flags[1])
`endif
    );

    // Issue one command from IDLE, measure accept-to-rsp_valid cycles, hold
    // rsp_ready low for 'stall' cycles, then complete the handshake.
    task automatic run_cmd(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input int stall, output int lat,
                           output logic [31:0] data, output logic [3:0] flags);
        req_a[k] = a; req_b[k] = b; req_op[k] = op; req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        data  = rsp_data[k];
        flags = rsp_flags[k];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
            req_a[k] = '0; req_b[k] = '0; req_op[k] = '0;
`ifdef FPU_STICKY_FLAGS_EN
            sticky_clr[k] = 1'b0;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req_ready[k], rsp_valid[k], rsp_data[k], rsp_flags[k], a_op[k], b_op[k], op_out[k]} !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b data=%h flags=%h a=%h b=%h op=%h, expected all 0",
                         k, req_ready[k], rsp_valid[k], rsp_data[k], rsp_flags[k], a_op[k], b_op[k], op_out[k]);
            end
            rst_n[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset[%0d]: got %b, expected 1", k, req_ready[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat; logic [31:0] d; logic [3:0] f;
        run_cmd(0, 32'h404E_B852, 32'h3FC0_0000, 4'd0, 0, lat, d, f);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d, expected 2", lat); end
        checks++;
        if (d !== stub_result(32'h404E_B852, 32'h3FC0_0000, 4'd0)) begin
            errors++; $display("FAIL add_data: got %h, expected %h", d, stub_result(32'h404E_B852, 32'h3FC0_0000, 4'd0));
        end
        checks++;
        if (f !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b, expected 0000", f); end
        checks++;
        if (op_out[0] !== 4'd0 || a_op[0] !== 32'h404E_B852 || b_op[0] !== 32'h3FC0_0000) begin
            errors++; $display("FAIL add_drive_held: got a=%h b=%h op=%h, expected 404eb852 3fc00000 0", a_op[0], b_op[0], op_out[0]);
        end
    endtask

    task automatic test_div_exception();
        int lat; logic [31:0] d; logic [3:0] f;
        run_cmd(0, 32'h4000_0000, 32'h0000_0000, 4'd3, 0, lat, d, f);
        checks++;
        if (f !== 4'b0100) begin errors++; $display("FAIL div_flags: got %b, expected 0100", f); end
        checks++;
        if (lat !== 2 || d !== stub_result(32'h4000_0000, 32'h0, 4'd3)) begin
            errors++; $display("FAIL div_resp: got lat=%0d data=%h, expected lat=2 data=%h", lat, d, stub_result(32'h4000_0000, 32'h0, 4'd3));
        end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] d; logic [3:0] f;
        run_cmd(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 0, lat, d, f);
        checks++;
        if (d !== 32'h7FC0_0000 || f !== 4'b1000) begin
            errors++; $display("FAIL illegal_resp: got data=%h flags=%b, expected 7fc00000 1000", d, f);
        end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d, expected 1", lat); end
        checks++;
        if (a_op[0] !== 32'h4000_0000 || b_op[0] !== 32'h0 || op_out[0] !== 4'd3) begin
            errors++; $display("FAIL illegal_drive: got a=%h b=%h op=%h, expected 40000000 00000000 3", a_op[0], b_op[0], op_out[0]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a1 = 32'h3F80_0000, b1 = 32'h4000_0000;
        logic [31:0] a2 = 32'hC0A0_0001, b2 = 32'h4120_0000;
        int lat;
        req_a[0] = a1; req_b[0] = b1; req_op[0] = 4'd2; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (rsp_valid[0] !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL stall_latency: got %0d, expected 2", lat); end
        req_a[0] = a2; req_b[0] = b2; req_op[0] = 4'd1; req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || rsp_data[0] !== exp_data(a1, b1, 4'd2) ||
                rsp_flags[0] !== exp_flags(a1, b1, 4'd2) || a_op[0] !== a1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b data=%h flags=%b a=%h, expected 1 0 %h %b %h",
                         i, rsp_valid[0], req_ready[0], rsp_data[0], rsp_flags[0], a_op[0],
                         exp_data(a1, b1, 4'd2), exp_flags(a1, b1, 4'd2), a1);
            end
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || a_op[0] !== a1) begin
            errors++; $display("FAIL stall_release: got vld=%b rdy=%b a=%h, expected 0 1 %h", rsp_valid[0], req_ready[0], a_op[0], a1);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (rsp_valid[0] !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 2 || rsp_data[0] !== exp_data(a2, b2, 4'd1) || a_op[0] !== a2) begin
            errors++; $display("FAIL stall_second: got lat=%0d data=%h a=%h, expected 2 %h %h", lat, rsp_data[0], a_op[0], exp_data(a2, b2, 4'd1), a2);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_random(input int k, input int n);
        int lat; logic [31:0] d; logic [3:0] f;
        logic [31:0] a, b, drv_a, drv_b; logic [3:0] op, drv_op;
        drv_a = a_op[k]; drv_b = b_op[k]; drv_op = op_out[k];
        for (int i = 0; i < n; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            if (op <= 4'd3) begin drv_a = a; drv_b = b; drv_op = op; end
            checks++;
            if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d.%0d]: got %b, expected 1", k, i, req_ready[k]); end
            run_cmd(k, a, b, op, $urandom_range(0, 3), lat, d, f);
            checks++;
            if (lat !== exp_lat(lat_of(k), op)) begin
                errors++; $display("FAIL rand_latency[%0d.%0d]: got %0d, expected %0d", k, i, lat, exp_lat(lat_of(k), op));
            end
            checks++;
            if (d !== exp_data(a, b, op) || f !== exp_flags(a, b, op)) begin
                errors++; $display("FAIL rand_resp[%0d.%0d]: got %h/%b, expected %h/%b", k, i, d, f, exp_data(a, b, op), exp_flags(a, b, op));
            end
            checks++;
            if (a_op[k] !== drv_a || b_op[k] !== drv_b || op_out[k] !== drv_op) begin
                errors++; $display("FAIL rand_drive[%0d.%0d]: got %h %h %h, expected %h %h %h", k, i, a_op[k], b_op[k], op_out[k], drv_a, drv_b, drv_op);
            end
        end
    endtask

    // req_valid and rsp_ready held high: accepts must be exactly FPU_LAT+2 apart.
    task automatic test_back_to_back(input int k);
        int lat = lat_of(k);
        int last = 0, nacc = 0;
        logic [31:0] a = $urandom, b = $urandom;
        logic [3:0] op = 4'($urandom_range(0, 3));
        req_a[k] = a; req_b[k] = b; req_op[k] = op;
        req_valid[k] = 1'b1; rsp_ready[k] = 1'b1;
        for (int c = 0; c < 5 * (lat + 2); c++) begin
            if (req_ready[k] === 1'b1) begin
                if (nacc > 0) begin
                    checks++;
                    if (c - last !== lat + 2) begin
                        errors++; $display("FAIL b2b_gap[%0d]: got %0d, expected %0d", k, c - last, lat + 2);
                    end
                end
                last = c; nacc++;
            end
            if (rsp_valid[k] === 1'b1) begin
                checks++;
                if (rsp_data[k] !== exp_data(a, b, op)) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %h, expected %h", k, rsp_data[k], exp_data(a, b, op));
                end
            end
            @(posedge clk); #1;
        end
        req_valid[k] = 1'b0;
        checks++;
        if (nacc < 3) begin errors++; $display("FAIL b2b_count[%0d]: got %0d accepts, expected >= 3", k, nacc); end
        for (int c = 0; c < 20 && req_ready[k] !== 1'b1; c++) begin @(posedge clk); #1; end
        rsp_ready[k] = 1'b0;
        checks++;
        if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL b2b_drain[%0d]: got ready %b, expected 1", k, req_ready[k]); end
    endtask

    task automatic test_reset_mid_wait();
        int stale = 0;
        req_a[1] = 32'h4049_0FDB; req_b[1] = 32'h3F80_0001; req_op[1] = 4'd2; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        checks++;
        if ({req_ready[1], rsp_valid[1], rsp_data[1], rsp_flags[1], a_op[1], b_op[1], op_out[1]} !== '0) begin
            errors++;
            $display("FAIL midwait_reset: got rdy=%b vld=%b data=%h flags=%b a=%h b=%h op=%h, expected all 0",
                     req_ready[1], rsp_valid[1], rsp_data[1], rsp_flags[1], a_op[1], b_op[1], op_out[1]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL midwait_ready_low: got %b, expected 0", req_ready[1]); end
        rst_n[1] = 1'b1;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL midwait_ready_release: got %b, expected 1", req_ready[1]); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[1] !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin errors++; $display("FAIL midwait_stale: got %0d rsp_valid cycles, expected 0", stale); end
    endtask

`ifdef FPU_STICKY_FLAGS_EN
    task automatic test_sticky();
        int lat; logic [31:0] d; logic [3:0] f;
        sticky_clr[0] = 1'b1;
        @(posedge clk); #1;
        sticky_clr[0] = 1'b0;
        checks++;
        if (sticky_flags[0] !== 4'b0000) begin errors++; $display("FAIL sticky_init: got %b, expected 0000", sticky_flags[0]); end
        run_cmd(0, 32'h3F80_0001, 32'h4000_0000, 4'd0, 1, lat, d, f);
        checks++;
        if (sticky_flags[0] !== 4'b0010) begin errors++; $display("FAIL sticky_first: got %b, expected 0010", sticky_flags[0]); end
        run_cmd(0, 32'h3F80_0000, 32'h4000_0001, 4'd1, 0, lat, d, f);
        checks++;
        if (sticky_flags[0] !== 4'b0011) begin errors++; $display("FAIL sticky_accum: got %b, expected 0011", sticky_flags[0]); end
        sticky_clr[0] = 1'b1;
        @(posedge clk); #1;
        sticky_clr[0] = 1'b0;
        checks++;
        if (sticky_flags[0] !== 4'b0000) begin errors++; $display("FAIL sticky_clear: got %b, expected 0000", sticky_flags[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_div_exception();
        test_illegal();
        test_stall();
        test_random(0, 25);
        test_random(1, 15);
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid_wait();
`ifdef FPU_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
